seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
Controller that sequences parallel words through a serial pattern detector. It accepts a WORD_W-bit word on a valid/ready handshake and shifts it MSB-first, one bit per clock, through an internal programmable PAT_W-bit Moore-style pattern matcher. It counts overlapping matches and returns a result record on a second valid/ready handshake. It sits between a word-oriented producer/consumer and the bit-serial detection datapath, and owns the detector's configuration.

Parameters:
WORD_W, 32, bits per scanned word (>= PAT_W)
PAT_W, 4, pattern length in bits
CNT_W, 6, match counter width (saturating)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
cfg_we  in  1  pattern write strobe
cfg_pattern  in  PAT_W  new pattern value
in_valid  in  1  word available
in_ready  out  1  controller can accept word
in_word  in  WORD_W  word to scan
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_count  out  CNT_W  number of matches in word
out_found  out  1  at least one match
out_first_pos  out  $clog2(WORD_W)  bit index (0 = first bit shifted) where first match completed
busy  out  1  state != IDLE
ser_bit  out  1  bit currently presented to matcher (debug)
match_pulse  out  1  one-cycle pulse on each match

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_count=0, out_found=0, out_first_pos=0, busy=0, ser_bit=0, match_pulse=0, history=0, bits_seen=0, pattern=4'b1010 (low PAT_W bits of 1010 zero-extended if PAT_W≠4).
- FSM states: IDLE, SHIFT, REPORT.
- IDLE: in_ready=1. On in_valid&in_ready: latch in_word into shift reg, clear count/found/first_pos, bit index=0, go SHIFT.
- SHIFT: each cycle present shreg[WORD_W-1] on ser_bit, shift left. history <= {history[PAT_W-2:0], bit}; bits_seen increments, saturating at PAT_W.
- Match when the updated history == pattern and updated bits_seen >= PAT_W. On match: match_pulse=1 the same cycle; count+1, saturating at 2^CNT_W-1. On the first match: found=1 and first_pos=current bit index.
- Overlapping matches are counted (0xA… with pattern 1010 counts every 2 bits after the first).
- After bit index WORD_W-1 is processed, go REPORT. Exactly WORD_W SHIFT cycles.
- REPORT: out_valid=1 with stable outputs until out_ready. On out_valid&out_ready go IDLE.
- Latency: word accepted at edge T; out_valid high after edge T+WORD_W. No new word is accepted until the result is taken (in_ready=0 in SHIFT/REPORT).
- cfg_we is honoured only in IDLE; ignored (pattern unchanged) in SHIFT/REPORT. If cfg_we and input accept coincide in IDLE, the new pattern applies to that word.
- Without carry mode, history and bits_seen are cleared at each word accept.
- rst mid-SHIFT or mid-REPORT aborts the scan and discards the result. All state returns to reset values, including the pattern.

Optional Feature:
SEQ_SCAN_CARRY_EN. Defined: history and bits_seen are NOT cleared at word accept, so a pattern spanning a word boundary is detected and is counted in the later word. They clear only on rst or on a cfg_we write. Undefined: each word is scanned independently, with history cleared at accept.

Test Plan:
- Reset, pattern 1010, word 0xA0000000 -> out_valid at T+32, count=1, found=1, first_pos=3, exactly one match_pulse.
- Word 0xAAAAAAAA -> count=15, first_pos=3, match_pulse on bit indices 3,5,...,31.
- Word 0x00000000 -> count=0, found=0, first_pos=0. Then cfg pattern 4'b1111, word 0xFFFFFFFF -> count=29, first_pos=3.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT -> out_valid and outputs stable, in_ready=0, and a word offered meanwhile is accepted only after the result is taken. A cfg_we during SHIFT leaves pattern unchanged.
- Words 0x00000001 then 0x40000000, pattern 1010 -> with SEQ_SCAN_CARRY_EN: second result count=1, first_pos=2. Without: both counts 0.
- Assert rst at SHIFT bit index 10 of 0xAAAAAAAA -> next cycle IDLE, in_ready=1, out_valid=0, pattern=1010, and no result emitted for the aborted word.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit-serial scan controller driving a programmable Moore pattern matcher.
// Build option SEQ_SCAN_CARRY_EN keeps matcher history across word boundaries.
module seq_scan_ctrl #(
    parameter int WORD_W = 32,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [PAT_W-1:0]          cfg_pattern,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_word,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_found,
    output logic [$clog2(WORD_W)-1:0] out_first_pos,
    output logic                      busy,
    output logic                      ser_bit,
    output logic                      match_pulse
);

    localparam int POS_W  = $clog2(WORD_W);
    localparam int SEEN_W = $clog2(PAT_W + 1);

    localparam logic [PAT_W-1:0]  PAT_RST  = PAT_W'(4'b1010);
    localparam logic [POS_W-1:0]  LAST_IDX = POS_W'(WORD_W - 1);
    localparam logic [SEEN_W-1:0] SEEN_MAX = SEEN_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // Both handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; valid and its payload stay stable until that edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   shreg;
    logic [PAT_W-1:0]    pattern;
    logic [PAT_W-1:0]    history;
    logic [SEEN_W-1:0]   bits_seen;
    logic [POS_W-1:0]    bit_idx;

    logic [PAT_W-1:0]    history_nxt;
    logic [SEEN_W-1:0]   seen_nxt;
    logic                hit;

    // Matcher decision uses the history as it will look after this bit.
    always_comb begin
        history_nxt = '0;
        seen_nxt    = '0;
        hit         = 1'b0;
        history_nxt = (history << 1) | PAT_W'(shreg[WORD_W-1]);
        seen_nxt    = (bits_seen == SEEN_MAX) ? bits_seen : bits_seen + 1'b1;
        hit         = (history_nxt == pattern) && (seen_nxt >= SEEN_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            pattern       <= PAT_RST;
            history       <= '0;
            bits_seen     <= '0;
            bit_idx       <= '0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_count     <= '0;
            out_found     <= 1'b0;
            out_first_pos <= '0;
            busy          <= 1'b0;
            ser_bit       <= 1'b0;
            match_pulse   <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    // A pattern write also restarts the matcher history.
                    if (cfg_we) begin
                        pattern   <= cfg_pattern;
                        history   <= '0;
                        bits_seen <= '0;
                    end
                    if (in_valid) begin
                        shreg         <= in_word;
                        out_count     <= '0;
                        out_found     <= 1'b0;
                        out_first_pos <= '0;
                        bit_idx       <= '0;
`ifdef SEQ_SCAN_CARRY_EN
`else
                        history       <= '0;
                        bits_seen     <= '0;
`endif
                        state         <= SHIFT;
                        in_ready      <= 1'b0;
                        busy          <= 1'b1;
                    end
                end

                SHIFT: begin
                    ser_bit   <= shreg[WORD_W-1];
                    shreg     <= shreg << 1;
                    history   <= history_nxt;
                    bits_seen <= seen_nxt;
                    if (hit) begin
                        match_pulse <= 1'b1;
                        if (out_count != CNT_MAX) begin
                            out_count <= out_count + 1'b1;
                        end
                        if (!out_found) begin
                            out_found     <= 1'b1;
                            out_first_pos <= bit_idx;
                        end
                    end
                    if (bit_idx == LAST_IDX) begin
                        state     <= REPORT;
                        out_valid <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end

                REPORT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed and random scan bench for seq_scan_ctrl; follows SEQ_SCAN_CARRY_EN when defined.
module tb_seq_scan_ctrl;

    localparam int WORD_W = 32;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 6;
    localparam int POS_W  = 5;
    localparam int EW     = WORD_W + CNT_W + 1 + POS_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_found;
    logic [POS_W-1:0]  out_first_pos;
    logic              busy;
    logic              ser_bit;
    logic              match_pulse;

    int total = 0;
    int bad   = 0;

    // Expected record: {pulse mask by bit index, count, found, first_pos}
    logic [EW-1:0] exp_q[$];

    logic [PAT_W-1:0] m_hist;
    logic [PAT_W-1:0] m_pat;
    int               m_seen;

    seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_pattern  (cfg_pattern),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_count    (out_count),
        .out_found    (out_found),
        .out_first_pos(out_first_pos),
        .busy         (busy),
        .ser_bit      (ser_bit),
        .match_pulse  (match_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [CNT_W-1:0] c, input logic f,
                            input logic [POS_W-1:0] p, input logic [WORD_W-1:0] m);
        exp_q.push_back({m, c, f, p});
    endtask

    // Reference scan of one word, MSB first, with overlapping matches.
    task automatic model_scan(input logic [WORD_W-1:0] w, output logic [CNT_W-1:0] c,
                              output logic f, output logic [POS_W-1:0] p,
                              output logic [WORD_W-1:0] m);
        c = '0; f = 1'b0; p = '0; m = '0;
`ifndef SEQ_SCAN_CARRY_EN
        m_hist = '0;
        m_seen = 0;
`endif
        for (int i = 0; i < WORD_W; i++) begin
            m_hist = {m_hist[PAT_W-2:0], w[WORD_W-1-i]};
            if (m_seen < PAT_W) m_seen++;
            if (m_seen >= PAT_W && m_hist == m_pat) begin
                if (c != '1) c = c + 1'b1;
                if (!f) begin
                    f = 1'b1;
                    p = POS_W'(i);
                end
                m[i] = 1'b1;
            end
        end
    endtask

    task automatic cfg_write(input logic [PAT_W-1:0] val);
        cfg_we      = 1'b1;
        cfg_pattern = val;
        step();
        cfg_we      = 1'b0;
    endtask

    task automatic send(input logic [WORD_W-1:0] w, input bit cfg_now, input logic [PAT_W-1:0] cfg_val);
        int n;
        n        = 0;
        in_word  = w;
        in_valid = 1'b1;
        if (cfg_now) begin
            cfg_we      = 1'b1;
            cfg_pattern = cfg_val;
        end
        while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("accept_wait_bound", 64'(n < 100), 64'd1);
        step();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("in_ready_in_shift", 64'(in_ready), 64'd0);
    endtask

    task automatic run_bits(input logic [WORD_W-1:0] w, input int cfg_bit,
                            input logic [PAT_W-1:0] cfg_val, output logic [WORD_W-1:0] mask);
        mask = '0;
        for (int i = 0; i < WORD_W; i++) begin
            if (i == cfg_bit) begin
                cfg_we      = 1'b1;
                cfg_pattern = cfg_val;
            end
            step();
            cfg_we  = 1'b0;
            mask[i] = match_pulse;
            check("ser_bit", 64'(ser_bit), 64'(w[WORD_W-1-i]));
            if (i < WORD_W - 1) check("out_valid_early", 64'(out_valid), 64'd0);
        end
        check("out_valid_latency", 64'(out_valid), 64'd1);
    endtask

    task automatic take_result(input logic [WORD_W-1:0] mask, input int hold,
                               input bit offer, input logic [WORD_W-1:0] offer_word);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: observed=result expected=no_result");
        end else begin
            e = exp_q.pop_front();
            check("out_count", 64'(out_count), 64'(e[11:6]));
            check("out_found", 64'(out_found), 64'(e[5]));
            check("out_first_pos", 64'(out_first_pos), 64'(e[4:0]));
            check("match_pulse_mask", 64'(mask), 64'(e[EW-1:12]));
            if (offer) begin
                in_valid = 1'b1;
                in_word  = offer_word;
            end
            for (int k = 0; k < hold; k++) begin
                step();
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_in_ready", 64'(in_ready), 64'd0);
                check("hold_count", 64'(out_count), 64'(e[11:6]));
                check("hold_first_pos", 64'(out_first_pos), 64'(e[4:0]));
                check("hold_found", 64'(out_found), 64'(e[5]));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("out_valid_after_take", 64'(out_valid), 64'd0);
            check("in_ready_after_take", 64'(in_ready), 64'd1);
            check("busy_after_take", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [WORD_W-1:0] mk;
        logic [WORD_W-1:0] w;
        logic [CNT_W-1:0]  c;
        logic              f;
        logic [POS_W-1:0]  p;
        logic [WORD_W-1:0] m;
        logic [PAT_W-1:0]  pat;
        bit                saw;

        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; in_valid = 1'b0;
        in_word = '0; out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_found", 64'(out_found), 64'd0);
        check("rst_first_pos", 64'(out_first_pos), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ser_bit", 64'(ser_bit), 64'd0);
        check("rst_match_pulse", 64'(match_pulse), 64'd0);
        rst = 1'b0;
        step();

        // Default pattern 1010, single match.
        push_exp(6'd1, 1'b1, 5'd3, 32'h0000_0008);
        send(32'hA000_0000, 1'b0, '0);
        run_bits(32'hA000_0000, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);

        // Overlapping matches.
        push_exp(6'd15, 1'b1, 5'd3, 32'hAAAA_AAA8);
        send(32'hAAAA_AAAA, 1'b0, '0);
        run_bits(32'hAAAA_AAAA, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);

        push_exp(6'd0, 1'b0, 5'd0, 32'h0);
        send(32'h0000_0000, 1'b0, '0);
        run_bits(32'h0000_0000, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);

        cfg_write(4'b1111);
        push_exp(6'd29, 1'b1, 5'd3, 32'hFFFF_FFF8);
        send(32'hFFFF_FFFF, 1'b0, '0);
        run_bits(32'hFFFF_FFFF, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);

        // Pattern write coinciding with accept applies to that word.
        push_exp(6'd1, 1'b1, 5'd3, 32'h0000_0008);
        send(32'hA000_0000, 1'b1, 4'b1010);
        run_bits(32'hA000_0000, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);

        // Pattern write during SHIFT is ignored; backpressure with a word on offer.
        push_exp(6'd15, 1'b1, 5'd3, 32'hAAAA_AAA8);
        send(32'hAAAA_AAAA, 1'b0, '0);
        run_bits(32'hAAAA_AAAA, 10, 4'b1111, mk);
`ifdef SEQ_SCAN_CARRY_EN
        push_exp(6'd2, 1'b1, 5'd1, 32'h0000_000A);
`else
        push_exp(6'd1, 1'b1, 5'd3, 32'h0000_0008);
`endif
        take_result(mk, 5, 1'b1, 32'hA000_0000);
        send(32'hA000_0000, 1'b0, '0);
        run_bits(32'hA000_0000, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);

        // Pattern spanning a word boundary.
        cfg_write(4'b1010);
        push_exp(6'd0, 1'b0, 5'd0, 32'h0);
        send(32'h0000_0001, 1'b0, '0);
        run_bits(32'h0000_0001, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);
`ifdef SEQ_SCAN_CARRY_EN
        push_exp(6'd1, 1'b1, 5'd2, 32'h0000_0004);
`else
        push_exp(6'd0, 1'b0, 5'd0, 32'h0);
`endif
        send(32'h4000_0000, 1'b0, '0);
        run_bits(32'h4000_0000, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);

        // Random patterns and words against the reference scan.
        for (int r = 0; r < 3; r++) begin
            pat = PAT_W'($urandom_range(0, 15));
            cfg_write(pat);
            m_pat  = pat;
            m_hist = '0;
            m_seen = 0;
            for (int k = 0; k < 3; k++) begin
                w = $urandom;
                if (k == 0) w[WORD_W-1 -: 8] = 8'($urandom_range(0, 255));
                model_scan(w, c, f, p, m);
                push_exp(c, f, p, m);
                send(w, 1'b0, '0);
                run_bits(w, -1, '0, mk);
                take_result(mk, 0, 1'b0, '0);
            end
        end

        // Reset mid-scan: aborts the word and restores pattern 1010.
        cfg_write(4'b1111);
        send(32'hAAAA_AAAA, 1'b0, '0);
        repeat (10) step();
        rst = 1'b1;
        step();
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_match_pulse", 64'(match_pulse), 64'd0);
        check("abort_ser_bit", 64'(ser_bit), 64'd0);
        check("abort_out_count", 64'(out_count), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            step();
            if (out_valid) saw = 1'b1;
        end
        out_ready = 1'b0;
        check("abort_no_result", 64'(saw), 64'd0);
        push_exp(6'd1, 1'b1, 5'd3, 32'h0000_0008);
        send(32'hA000_0000, 1'b0, '0);
        run_bits(32'hA000_0000, -1, '0, mk);
        take_result(mk, 0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
